// File: rtl/sprite_compositor_multi.sv
// sprite_compositor_multi
//   Composites NUM_SPRITES independently placed SPRITE_W x SPRITE_H sprites, drawn from one
//   shared sprite sheet and one shared palette, into the VGA pixel stream. Four pipeline
//   stages: box test, sheet lookup, fixed-priority select, palette lookup.
//   Optional macro: SPRITE_MIRROR_EN adds the spriteMirror port (per-sprite horizontal flip).
//   Sheet and palette ROM contents are generated in-module.
module sprite_compositor_multi #(
    parameter int                    NUM_SPRITES     = 4,
    parameter int                    SPRITE_W        = 50,
    parameter int                    SPRITE_H        = 50,
    parameter int                    X_WIDTH         = 10,
    parameter int                    Y_WIDTH         = 9,
    parameter int                    COLOR_BITS      = 12,
    parameter int                    PAL_ADDR_W      = 9,
    parameter int                    TRANSPARENT_IDX = 0,
    parameter logic [COLOR_BITS-1:0] BG_COLOR        = 12'h000,
    parameter string                 SHEET_MEM       = "../assetsMemFiles/spritesheet.mem",
    parameter string                 PAL_MEM         = "../assetsMemFiles/spritecolors.mem",
    localparam int                   ID_W            = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           frameStart,
    input  logic                           pixValidIn,
    input  logic [X_WIDTH-1:0]             x,
    input  logic [Y_WIDTH-1:0]             y,
    input  logic [NUM_SPRITES*X_WIDTH-1:0] spriteX,
    input  logic [NUM_SPRITES*Y_WIDTH-1:0] spriteY,
    input  logic [NUM_SPRITES-1:0]         spriteEn,
`ifdef SPRITE_MIRROR_EN
    input  logic [NUM_SPRITES-1:0]         spriteMirror,
`endif
    output logic                           pixValidOut,
    output logic                           hit,
    output logic [ID_W-1:0]                hitId,
    output logic [COLOR_BITS-1:0]          out
);

    localparam int SheetDepth = NUM_SPRITES * SPRITE_W * SPRITE_H;
    localparam int AddrW      = $clog2(SheetDepth);

    localparam logic [X_WIDTH:0]      WLim      = (X_WIDTH + 1)'(SPRITE_W);
    localparam logic [X_WIDTH:0]      WLast     = (X_WIDTH + 1)'(SPRITE_W - 1);
    localparam logic [Y_WIDTH:0]      HLim      = (Y_WIDTH + 1)'(SPRITE_H);
    localparam logic [PAL_ADDR_W-1:0] TranspIdx = PAL_ADDR_W'(TRANSPARENT_IDX);

    // Generated sheet contents: index 0 wherever the low address nibble is 5, otherwise a
    // non-zero index whose low nibble is never 0.
    function automatic logic [PAL_ADDR_W-1:0] sheetPattern(input logic [AddrW-1:0] a);
        logic [31:0] w;
        w = 32'(a);
        if (w[3:0] == 4'd5) return '0;
        return PAL_ADDR_W'((w ^ 32'd5) ^ ((w >> 9) << 4));
    endfunction

    function automatic logic [COLOR_BITS-1:0] palPattern(input logic [PAL_ADDR_W-1:0] p);
        return COLOR_BITS'(32'(p) * 32'd23 + 32'd1445);
    endfunction

    logic [NUM_SPRITES*X_WIDTH-1:0] shX;
    logic [NUM_SPRITES*Y_WIDTH-1:0] shY;
    logic [NUM_SPRITES-1:0]         shEn;
`ifdef SPRITE_MIRROR_EN
    logic [NUM_SPRITES-1:0]         shMirror;
`endif

    // Shadow position registers, updated only at frame start so a frame never tears.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shX  <= '0;
            shY  <= '0;
            shEn <= '0;
`ifdef SPRITE_MIRROR_EN
            shMirror <= '0;
`endif
        end else if (frameStart) begin
            shX  <= spriteX;
            shY  <= spriteY;
            shEn <= spriteEn;
`ifdef SPRITE_MIRROR_EN
            shMirror <= spriteMirror;
`endif
        end
    end

    logic [NUM_SPRITES-1:0] inBoxD;
    logic [AddrW-1:0]       addrD [NUM_SPRITES];

    // Per-sprite box test and sheet address for the current pixel.
    always_comb begin
        logic [X_WIDTH:0] dx;
        logic [Y_WIDTH:0] dy;
        logic [X_WIDTH:0] col;
        logic             mirror;
        dx     = '0;
        dy     = '0;
        col    = '0;
        mirror = 1'b0;
        inBoxD = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            // Extra MSB acts as a sign: x < sx sets it rather than wrapping into the box.
            dx = {1'b0, x} - {1'b0, shX[i*X_WIDTH +: X_WIDTH]};
            dy = {1'b0, y} - {1'b0, shY[i*Y_WIDTH +: Y_WIDTH]};
`ifdef SPRITE_MIRROR_EN
            mirror = shMirror[i];
`endif
            col = mirror ? (WLast - dx) : dx;
            inBoxD[i] = shEn[i] & ~dx[X_WIDTH] & (dx < WLim) & ~dy[Y_WIDTH] & (dy < HLim);
            addrD[i] = '0;
            if (inBoxD[i]) begin
                addrD[i] = AddrW'(i * SPRITE_W * SPRITE_H) + AddrW'(dy) * AddrW'(SPRITE_W)
                         + AddrW'(col);
            end
        end
    end

    logic [NUM_SPRITES-1:0] inBox1;
    logic [AddrW-1:0]       addr1 [NUM_SPRITES];
    logic                   valid1;

    // Stage 1 register: box result and sheet address.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inBox1 <= '0;
            valid1 <= 1'b0;
            for (int i = 0; i < NUM_SPRITES; i++) addr1[i] <= '0;
        end else begin
            inBox1 <= inBoxD;
            valid1 <= pixValidIn;
            for (int i = 0; i < NUM_SPRITES; i++) addr1[i] <= addrD[i];
        end
    end

    logic [PAL_ADDR_W-1:0] sheetRd [NUM_SPRITES];

    // One read port per channel; synthesis replicates the sheet ROM per port.
    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) sheetRd[i] = sheetPattern(addr1[i]);
    end

    logic [NUM_SPRITES-1:0] inBox2;
    logic [PAL_ADDR_W-1:0]  idx2 [NUM_SPRITES];
    logic                   valid2;

    // Stage 2 register: synchronous sheet read with box/valid carried alongside.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inBox2 <= '0;
            valid2 <= 1'b0;
            for (int i = 0; i < NUM_SPRITES; i++) idx2[i] <= '0;
        end else begin
            inBox2 <= inBox1;
            valid2 <= valid1;
            for (int i = 0; i < NUM_SPRITES; i++) idx2[i] <= sheetRd[i];
        end
    end

    logic                  winFound;
    logic [ID_W-1:0]       winId;
    logic [PAL_ADDR_W-1:0] winIdx;

    // Fixed priority: scanning downward leaves the lowest opaque index as the winner.
    always_comb begin
        winFound = 1'b0;
        winId    = '0;
        winIdx   = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (inBox2[i] && (idx2[i] != TranspIdx)) begin
                winFound = 1'b1;
                winId    = ID_W'(i);
                winIdx   = idx2[i];
            end
        end
    end

    logic                  hit3;
    logic [ID_W-1:0]       hitId3;
    logic [PAL_ADDR_W-1:0] selIdx3;
    logic                  valid3;

    // Stage 3 register: winner, with invalid pixel slots never reporting a hit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hit3    <= 1'b0;
            hitId3  <= '0;
            selIdx3 <= '0;
            valid3  <= 1'b0;
        end else begin
            hit3    <= valid2 & winFound;
            hitId3  <= (valid2 & winFound) ? winId : '0;
            selIdx3 <= winIdx;
            valid3  <= valid2;
        end
    end

    logic [COLOR_BITS-1:0] palRd;

    assign palRd = palPattern(selIdx3);

    // Stage 4 register: synchronous palette read and final colour select.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out         <= BG_COLOR;
            hit         <= 1'b0;
            hitId       <= '0;
            pixValidOut <= 1'b0;
        end else begin
            out         <= hit3 ? palRd : BG_COLOR;
            hit         <= hit3;
            hitId       <= hitId3;
            pixValidOut <= valid3;
        end
    end

endmodule

// File: tb/tb_sprite_compositor_multi.sv
// tb_sprite_compositor_multi
//   Directed scenarios followed by randomized pixels around randomly placed, overlapping
//   sprites; every output is compared against a pixel-level reference model.
module tb_sprite_compositor_multi;

    localparam int NS = 4;
    localparam int W  = 50;
    localparam int H  = 50;
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int CB = 12;
    localparam logic [CB-1:0] BG = 12'h3C7;

    logic            clk;
    logic            resetn;
    logic            frameStart;
    logic            pixValidIn;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [NS*XW-1:0] spriteX;
    logic [NS*YW-1:0] spriteY;
    logic [NS-1:0]   spriteEn;
`ifdef SPRITE_MIRROR_EN
    logic [NS-1:0]   spriteMirror;
`endif
    logic            pixValidOut;
    logic            hit;
    logic [1:0]      hitId;
    logic [CB-1:0]   out;

    sprite_compositor_multi #(
        .NUM_SPRITES(NS),
        .SPRITE_W   (W),
        .SPRITE_H   (H),
        .X_WIDTH    (XW),
        .Y_WIDTH    (YW),
        .COLOR_BITS (CB),
        .PAL_ADDR_W (9),
        .BG_COLOR   (BG),
        .SHEET_MEM  (""),
        .PAL_MEM    ("")
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .frameStart  (frameStart),
        .pixValidIn  (pixValidIn),
        .x           (x),
        .y           (y),
        .spriteX     (spriteX),
        .spriteY     (spriteY),
        .spriteEn    (spriteEn),
`ifdef SPRITE_MIRROR_EN
        .spriteMirror(spriteMirror),
`endif
        .pixValidOut (pixValidOut),
        .hit         (hit),
        .hitId       (hitId),
        .out         (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit v;
        bit h;
        int id;
        int col;
    } exp_t;

    int   nCmp  = 0;
    int   nFail = 0;
    exp_t expQ[$];
    int   mX[NS];
    int   mY[NS];
    bit   mEn[NS];
    bit   mMir[NS];

    // Sheet image: transparent wherever address mod 16 is 5.
    function automatic int sheetRef(int a);
        if (a % 16 == 5) return 0;
        return ((a ^ 5) ^ ((a / 512) * 16)) % 512;
    endfunction

    function automatic int palRef(int p);
        return (p * 23 + 1445) % 4096;
    endfunction

    function automatic exp_t model(bit v, int px, int py);
        exp_t e;
        int dx, dy, c, idx;
        e.v = v; e.h = 0; e.id = 0; e.col = BG;
        if (v) begin
            for (int i = 0; i < NS; i++) begin
                dx = px - mX[i];
                dy = py - mY[i];
                if (!e.h && mEn[i] && dx >= 0 && dx < W && dy >= 0 && dy < H) begin
                    c   = mMir[i] ? (W - 1 - dx) : dx;
                    idx = sheetRef(i * W * H + dy * W + c);
                    if (idx != 0) begin
                        e.h = 1; e.id = i; e.col = palRef(idx);
                    end
                end
            end
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        check({tag, ".valid"}, 32'(pixValidOut), 32'd0);
        check({tag, ".hit"}, 32'(hit), 32'd0);
        check({tag, ".hitId"}, 32'(hitId), 32'd0);
        check({tag, ".out"}, 32'(out), 32'(BG));
    endtask

    task automatic modelReset();
        exp_t e;
        e.v = 0; e.h = 0; e.id = 0; e.col = BG;
        for (int i = 0; i < NS; i++) begin
            mX[i] = 0; mY[i] = 0; mEn[i] = 0; mMir[i] = 0;
        end
        expQ.delete();
        for (int k = 0; k < 3; k++) expQ.push_back(e);
    endtask

    task automatic place(input int i, input int sx, input int sy, input bit en, input bit mir);
        spriteX[i*XW +: XW] = XW'(sx);
        spriteY[i*YW +: YW] = YW'(sy);
        spriteEn[i] = en;
`ifdef SPRITE_MIRROR_EN
        spriteMirror[i] = mir;
`else
        if (mir) $display("note: mirror request ignored in this build");
`endif
    endtask

    // One pixel cycle: drive, predict, clock, then compare against the prediction from
    // four edges earlier.
    task automatic step(input string tag, input bit fs, input bit v, input int px, input int py);
        exp_t e;
        px = px & ((1 << XW) - 1);
        py = py & ((1 << YW) - 1);
        frameStart = fs; pixValidIn = v; x = XW'(px); y = YW'(py);
        expQ.push_back(model(v, px, py));
        if (fs) begin
            for (int i = 0; i < NS; i++) begin
                mX[i]  = int'(spriteX[i*XW +: XW]);
                mY[i]  = int'(spriteY[i*YW +: YW]);
                mEn[i] = spriteEn[i];
`ifdef SPRITE_MIRROR_EN
                mMir[i] = spriteMirror[i];
`endif
            end
        end
        @(posedge clk);
        #1;
        e = expQ.pop_front();
        check({tag, ".valid"}, 32'(pixValidOut), 32'(e.v));
        check({tag, ".hit"}, 32'(hit), 32'(e.h));
        check({tag, ".hitId"}, 32'(hitId), e.id);
        check({tag, ".out"}, 32'(out), e.col);
    endtask

    task automatic flush(input string tag);
        for (int k = 0; k < 3; k++) step(tag, 1'b0, 1'b0, 0, 0);
    endtask

    int k, px, py, bx, by;

    initial begin
        resetn = 1'b1; frameStart = 1'b0; pixValidIn = 1'b0; x = '0; y = '0;
        spriteX = '0; spriteY = '0; spriteEn = '0;
`ifdef SPRITE_MIRROR_EN
        spriteMirror = '0;
`endif
        modelReset();
        #2 resetn = 1'b0;

        // Reset held: outputs idle whatever the inputs do.
        place(0, 100, 200, 1'b1, 1'b0);
        for (int n = 0; n < 3; n++) begin
            x = XW'(100 + n); y = YW'(200); pixValidIn = 1'b1; frameStart = (n == 1);
            @(posedge clk);
            #1;
            checkIdle("rst_held");
        end
        resetn = 1'b1;
        modelReset();

        // Sprites invisible before the first frameStart.
        step("pre_fs", 1'b0, 1'b1, 100, 200);
        step("pre_fs", 1'b0, 1'b1, 120, 220);
        step("fs", 1'b1, 1'b1, 100, 200);
        // Corners inside the box.
        step("t2_tl", 1'b0, 1'b1, 100, 200);
        step("t2_br", 1'b0, 1'b1, 149, 249);
        // Just outside each edge.
        step("t3_l", 1'b0, 1'b1, 99, 200);
        step("t3_r", 1'b0, 1'b1, 150, 200);
        step("t3_b", 1'b0, 1'b1, 100, 250);
        step("t3_t", 1'b0, 1'b1, 100, 199);
        step("t3_inv", 1'b0, 1'b0, 120, 220);
        flush("t3_fl");

        // Overlap priority, then a transparent sprite-0 pixel uncovering sprite 2.
        place(0, 10, 10, 1'b1, 1'b0);
        place(2, 10, 10, 1'b1, 1'b0);
        step("t4_fs", 1'b1, 1'b0, 0, 0);
        step("t4_pri", 1'b0, 1'b1, 10, 10);
        place(0, 5, 10, 1'b1, 1'b0);
        step("t4_fs2", 1'b1, 1'b0, 0, 0);
        step("t4_transp", 1'b0, 1'b1, 10, 10);
        step("t4_both", 1'b0, 1'b1, 15, 10);
        spriteEn = '0;
        step("t4_fs3", 1'b1, 1'b0, 0, 0);
        step("t4_none", 1'b0, 1'b1, 15, 10);
        flush("t4_fl");

        // Mid-frame move is ignored until frameStart.
        place(0, 300, 300, 1'b1, 1'b0);
        step("t5_hold", 1'b0, 1'b1, 300, 300);
        step("t5_fs", 1'b1, 1'b1, 300, 300);
        step("t5_new", 1'b0, 1'b1, 300, 300);
        flush("t5_fl");

        // Partly off-screen sprite and no aliasing of x < sx.
        place(0, 620, 100, 1'b1, 1'b1);
        step("t6_fs", 1'b1, 1'b0, 0, 0);
        step("t6_in", 1'b0, 1'b1, 630, 120);
        step("t6_left", 1'b0, 1'b1, 5, 120);
        step("t6_edge", 1'b0, 1'b1, 620, 100);
        step("t6_far", 1'b0, 1'b1, 669, 149);
        place(1, 1000, 50, 1'b1, 1'b0);
        step("t6_fs2", 1'b1, 1'b0, 0, 0);
        step("t6_wrap", 1'b0, 1'b1, 10, 60);
        step("t6_hi", 1'b0, 1'b1, 1010, 60);
        flush("t6_fl");

        // Reset mid-frame flushes the pipeline and clears the shadow registers.
        step("mid_load", 1'b0, 1'b1, 630, 120);
        step("mid_load", 1'b0, 1'b1, 631, 121);
        resetn = 1'b0;
        #1;
        checkIdle("mid_rst");
        modelReset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        step("post_rst", 1'b0, 1'b1, 630, 120);
        step("post_rst", 1'b0, 1'b1, 1010, 60);
        flush("post_rst_fl");

        // Randomized clustered sprites, mid-frame moves and sparse frameStart.
        for (int n = 0; n < 600; n++) begin
            if (n % 50 == 0) begin
                bx = $urandom_range(0, 1023);
                by = $urandom_range(0, 511);
                for (int i = 0; i < NS; i++) begin
                    place(i, (bx + $urandom_range(0, 40)) % 1024, (by + $urandom_range(0, 40)) % 512,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
                end
            end else if ($urandom_range(0, 15) == 0) begin
                place($urandom_range(0, NS - 1), $urandom_range(0, 1023), $urandom_range(0, 511),
                      1'b1, $urandom_range(0, 1) == 1);
            end
            k  = $urandom_range(0, NS - 1);
            px = mX[k] + $urandom_range(0, W + 6) - 3;
            py = mY[k] + $urandom_range(0, H + 6) - 3;
            step("rand", (n % 50 == 1) || ($urandom_range(0, 19) == 0),
                 $urandom_range(0, 7) != 0, px, py);
        end
        flush("rand_fl");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
